rmw_long_latency_tbl: RTL and testbench
=======================================

# rmw_long_latency_tbl

Long-latency lookup table behind `rmw_long_latency_cache`. It accepts single-word reads tagged with an issue tag and returns the word exactly `LAT` cycles later with that tag echoed. It accepts single-word writebacks from the cache's completion path. After reset it self-clears all entries before accepting traffic.

## Interface
- `ID_W`, default 4: id width; table depth = 2^ID_W; must equal width of `rmw_long_latency_pkg::id_t`.
- `TAG_W`, default 3: tag width; must equal width of `tag_t`.
- `W`, default 32: word width; must equal width of `word_t`.
- `LAT`, default 8: read latency in cycles; legal range 2..32.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tbl_wr` in 1: write strobe.
- `tbl_wr_id` in ID_W: write address.
- `tbl_wr_word` in W: write data.
- `tbl_rd` in 1: read strobe.
- `tbl_rd_id` in ID_W: read address.
- `tbl_rd_itag` in TAG_W: issue tag carried with the read.
- `tbl_rd_word_vld_r` out 1: read response valid, registered.
- `tbl_rd_word_r` out W: read response word, registered.
- `tbl_rd_ctag_r` out TAG_W: completion tag, equal to the `tbl_rd_itag` of the originating read.
- `init_done_r` out 1: high once the post-reset clear has finished.

## Operation
- Storage: 2^ID_W × W flops/RAM.
- Delay line of `LAT` stages. Each stage holds `vld`, `id`, `tag`, `word`.
- Init FSM has two states, INIT and RUN.
  - Reset enters INIT with counter = 0.
  - INIT writes 0 to entry[counter] each cycle and increments the counter.
  - On counter = 2^ID_W−1 the FSM writes that entry and moves to RUN next cycle.
  - `init_done_r` = (state == RUN). INIT takes exactly 2^ID_W cycles.
- `tbl_rd`/`tbl_wr` asserted in INIT are dropped. A bind assertion flags either one in INIT.
- Read: in the issue cycle, the word is sampled from storage into stage 0 with `id` and `tag`. It shifts one stage per cycle with no stall or backpressure. Stage LAT−1 drives the registered outputs.
- Write: storage is updated at the clock edge of the strobe cycle.
- Same-cycle read and write to the same id: the read samples `tbl_wr_word` (write-first).
- Reads and writes to different ids are fully independent. One read and one write can be accepted every cycle.
- Responses come out in issue order. Back-to-back reads give back-to-back responses.
- Tags are opaque. Duplicate in-flight tags are legal and pass through unchanged.

## Timing
- Reset values:
  - `tbl_rd_word_vld_r` = 0.
  - `init_done_r` = 0.
  - All delay-stage `vld` = 0.
  - `tbl_rd_word_r` and `tbl_rd_ctag_r` are undefined until the first response. Their data flops are not reset.
- A read in cycle t gives `tbl_rd_word_vld_r` = 1 in cycle t+LAT, with the word and tag valid in that same cycle.
- The first accepted request is in cycle 2^ID_W after `rst` deasserts. `init_done_r` rises in that same cycle.
- `rst` asserted mid-operation:
  - all in-flight reads are discarded and no response is emitted after the reset cycle;
  - the FSM restarts INIT and re-clears storage.
- Id wrap-around at 2^ID_W−1 → 0 is natural truncation. No out-of-range ids exist.
- At most one response per cycle. `vld` of each stage is the registered copy of the previous stage's `vld`.

## Configuration
- `RMW_LONG_LATENCY_TBL_FWD_EN` defined:
  - each cycle, every valid delay stage whose `id` equals `tbl_wr_id` while `tbl_wr` = 1 replaces its `word` with `tbl_wr_word`;
  - each response therefore returns the storage value as of the cycle before emission (write forwarding into flight).
- Undefined:
  - in-flight words are frozen at issue;
  - a response returns the value as of the issue cycle, including the same-cycle write-first case;
  - forwarding comparators are not built.

## Test plan
- Init: deassert rst; check `init_done_r` = 0 for 16 cycles (ID_W=4) and rises in cycle 16; read id 5 → word 0x0000_0000 in cycle 16+LAT.
- Basic latency: write id 3 = 0xDEAD_BEEF; next cycle read id 3 with tag 2 → `tbl_rd_word_vld_r` exactly LAT cycles later, word 0xDEAD_BEEF, ctag 2; no other vld pulses.
- Streaming: read ids 0..7 with tags 0..7 on consecutive cycles → 8 consecutive responses starting at LAT, in order, tags 0..7.
- Write-first: same cycle write id 9 = 0x1234 and read id 9 → response 0x1234.
- Forwarding: read id 4 (old value 0xA), write id 4 = 0xB two cycles later → response 0xB with FWD_EN, 0xA without.
- Reset mid-flight: issue 3 reads, assert rst 2 cycles later for 1 cycle → no response ever; `init_done_r` low for 16 cycles; prior data reads back 0.

Source files
------------

// File: rtl/rmw_long_latency_tbl.sv
// Long-latency lookup table: fixed-latency tagged reads, single-word writes, self-clear after reset.
// Optional RMW_LONG_LATENCY_TBL_FWD_EN forwards writes into in-flight read words.
module rmw_long_latency_tbl #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned W     = 32,
  parameter int unsigned LAT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tbl_wr,
  input  logic [ID_W-1:0]  tbl_wr_id,
  input  logic [W-1:0]     tbl_wr_word,
  input  logic             tbl_rd,
  input  logic [ID_W-1:0]  tbl_rd_id,
  input  logic [TAG_W-1:0] tbl_rd_itag,
  output logic             tbl_rd_word_vld_r,
  output logic [W-1:0]     tbl_rd_word_r,
  output logic [TAG_W-1:0] tbl_rd_ctag_r,
  output logic             init_done_r
);

  localparam int unsigned DEPTH = 1 << ID_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   cnt_q;
  logic [W-1:0]      mem_q [DEPTH];

  logic [LAT-1:0]    vld_q;
  logic [TAG_W-1:0]  tag_q  [LAT];
  logic [W-1:0]      word_q [LAT];
  logic [W-1:0]      fwd_word_c [LAT-1];

  logic              run_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic [W-1:0]      rd_word_c;

  // Traffic is only taken once the clear sweep has finished.
  assign run_c    = (state_q == ST_RUN) && !rst;
  assign wr_acc_c = tbl_wr && run_c;
  assign rd_acc_c = tbl_rd && run_c;
  assign rd_word_c = (wr_acc_c && (tbl_wr_id == tbl_rd_id)) ? tbl_wr_word : mem_q[tbl_rd_id];

  // Init sweep: one entry cleared per cycle, RUN after the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + ID_W'(1);
      if (cnt_q == ID_W'(DEPTH - 1)) begin
        state_q <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc_c) begin
      mem_q[tbl_wr_id] <= tbl_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], rd_acc_c};
    end
  end

  // Payload stages are not reset; vld alone qualifies them.
  always_ff @(posedge clk) begin
    tag_q[0]  <= tbl_rd_itag;
    word_q[0] <= rd_word_c;
    for (int k = 1; k < int'(LAT); k++) begin
      tag_q[k]  <= tag_q[k-1];
      word_q[k] <= fwd_word_c[k-1];
    end
  end

`ifdef RMW_LONG_LATENCY_TBL_FWD_EN
  // Last stage id is never compared, so only LAT-1 id stages are kept.
  logic [ID_W-1:0] id_q [LAT-1];

  always_ff @(posedge clk) begin
    id_q[0] <= tbl_rd_id;
    for (int k = 1; k < int'(LAT) - 1; k++) begin
      id_q[k] <= id_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < int'(LAT) - 1; k++) begin
      fwd_word_c[k] = word_q[k];
      if (wr_acc_c && vld_q[k] && (id_q[k] == tbl_wr_id)) begin
        fwd_word_c[k] = tbl_wr_word;
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < int'(LAT) - 1; k++) begin
      fwd_word_c[k] = word_q[k];
    end
  end
`endif

  assign tbl_rd_word_vld_r = vld_q[LAT-1];
  assign tbl_rd_word_r     = word_q[LAT-1];
  assign tbl_rd_ctag_r     = tag_q[LAT-1];
  assign init_done_r       = (state_q == ST_RUN);

endmodule

// File: tb/tb_rmw_long_latency_tbl.sv
// Directed self-checking bench for rmw_long_latency_tbl (ID_W=4, LAT=8).
module tb_rmw_long_latency_tbl;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned W     = 32;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr;
  logic [ID_W-1:0]  wr_id;
  logic [W-1:0]     wr_word;
  logic             rd;
  logic [ID_W-1:0]  rd_id;
  logic [TAG_W-1:0] rd_tag;
  logic             vld;
  logic [W-1:0]     word;
  logic [TAG_W-1:0] ctag;
  logic             done;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  rmw_long_latency_tbl #(.ID_W(ID_W), .TAG_W(TAG_W), .W(W), .LAT(LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .tbl_wr            (wr),
    .tbl_wr_id         (wr_id),
    .tbl_wr_word       (wr_word),
    .tbl_rd            (rd),
    .tbl_rd_id         (rd_id),
    .tbl_rd_itag       (rd_tag),
    .tbl_rd_word_vld_r (vld),
    .tbl_rd_word_r     (word),
    .tbl_rd_ctag_r     (ctag),
    .init_done_r       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    wr_id = '0; wr_word = '0; rd_id = '0; rd_tag = '0;
    repeat (3) step();
    checks++;
    if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b expected 0", vld); end
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      checks++;
      if (done !== 1'b0) begin fails++; $display("FAIL init_done_low c%0d: got %b expected 0", i, done); end
      step();
    end
    checks++;
    if (done !== 1'b1) begin fails++; $display("FAIL init_done_rise: got %b expected 1", done); end
  endtask

  task automatic test_init_read();
    int t;
    t = cyc; rd = 1'b1; rd_id = 4'd5; rd_tag = 3'd1;
    step();
    rd = 1'b0;
    while (cyc <= t + int'(LAT) + 2) begin
      checks++;
      if (vld !== (cyc == t + int'(LAT))) begin
        fails++; $display("FAIL init_read_vld @+%0d: got %b expected %b", cyc - t, vld, (cyc == t + int'(LAT)));
      end
      if (cyc == t + int'(LAT)) begin
        checks++;
        if (word !== 32'h0) begin fails++; $display("FAIL init_read_word: got %h expected 00000000", word); end
        checks++;
        if (ctag !== 3'd1) begin fails++; $display("FAIL init_read_tag: got %0d expected 1", ctag); end
      end
      step();
    end
  endtask

  task automatic test_latency();
    int t;
    wr = 1'b1; wr_id = 4'd3; wr_word = 32'hDEAD_BEEF;
    step();
    wr = 1'b0;
    t = cyc; rd = 1'b1; rd_id = 4'd3; rd_tag = 3'd2;
    step();
    rd = 1'b0;
    while (cyc <= t + int'(LAT) + 3) begin
      checks++;
      if (vld !== (cyc == t + int'(LAT))) begin
        fails++; $display("FAIL latency_vld @+%0d: got %b expected %b", cyc - t, vld, (cyc == t + int'(LAT)));
      end
      if (cyc == t + int'(LAT)) begin
        checks++;
        if (word !== 32'hDEAD_BEEF) begin fails++; $display("FAIL latency_word: got %h expected deadbeef", word); end
        checks++;
        if (ctag !== 3'd2) begin fails++; $display("FAIL latency_tag: got %0d expected 2", ctag); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int k;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; wr_id = ID_W'(i); wr_word = 32'h100 + W'(i);
      step();
    end
    wr = 1'b0;
    t = cyc; rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_id = ID_W'(i); rd_tag = TAG_W'(i);
      step();
    end
    rd = 1'b0;
    while (cyc <= t + int'(LAT) + 10) begin
      k = cyc - t - int'(LAT);
      checks++;
      if (vld !== (k >= 0 && k < 8)) begin
        fails++; $display("FAIL stream_vld @+%0d: got %b expected %b", cyc - t, vld, (k >= 0 && k < 8));
      end
      if (k >= 0 && k < 8) begin
        checks++;
        if (word !== 32'h100 + W'(k)) begin fails++; $display("FAIL stream_word %0d: got %h expected %h", k, word, 32'h100 + W'(k)); end
        checks++;
        if (ctag !== TAG_W'(k)) begin fails++; $display("FAIL stream_tag %0d: got %0d expected %0d", k, ctag, k); end
      end
      step();
    end
  endtask

  task automatic test_write_first();
    int t;
    t = cyc;
    wr = 1'b1; wr_id = 4'd9; wr_word = 32'h0000_1234;
    rd = 1'b1; rd_id = 4'd9; rd_tag = 3'd5;
    step();
    wr = 1'b0; rd = 1'b0;
    while (cyc <= t + int'(LAT) + 2) begin
      checks++;
      if (vld !== (cyc == t + int'(LAT))) begin
        fails++; $display("FAIL wfirst_vld @+%0d: got %b expected %b", cyc - t, vld, (cyc == t + int'(LAT)));
      end
      if (cyc == t + int'(LAT)) begin
        checks++;
        if (word !== 32'h0000_1234) begin fails++; $display("FAIL wfirst_word: got %h expected 00001234", word); end
        checks++;
        if (ctag !== 3'd5) begin fails++; $display("FAIL wfirst_tag: got %0d expected 5", ctag); end
      end
      step();
    end
  endtask

  task automatic test_forward();
    int t;
    logic [W-1:0] exp_w;
`ifdef RMW_LONG_LATENCY_TBL_FWD_EN
    exp_w = 32'hB;
`else
    exp_w = 32'hA;
`endif
    wr = 1'b1; wr_id = 4'd4; wr_word = 32'hA;
    step();
    wr = 1'b0;
    t = cyc; rd = 1'b1; rd_id = 4'd4; rd_tag = 3'd3;
    step();
    rd = 1'b0;
    step();
    wr = 1'b1; wr_id = 4'd4; wr_word = 32'hB;
    step();
    wr = 1'b0;
    while (cyc <= t + int'(LAT) + 1) begin
      checks++;
      if (vld !== (cyc == t + int'(LAT))) begin
        fails++; $display("FAIL fwd_vld @+%0d: got %b expected %b", cyc - t, vld, (cyc == t + int'(LAT)));
      end
      if (cyc == t + int'(LAT)) begin
        checks++;
        if (word !== exp_w) begin fails++; $display("FAIL fwd_word: got %h expected %h", word, exp_w); end
      end
      step();
    end
    // Storage itself holds the newer value regardless of forwarding.
    t = cyc; rd = 1'b1; rd_id = 4'd4; rd_tag = 3'd6;
    step();
    rd = 1'b0;
    while (cyc < t + int'(LAT)) step();
    checks++;
    if (vld !== 1'b1 || word !== 32'hB) begin
      fails++; $display("FAIL fwd_readback: got vld=%b word=%h expected vld=1 word=0000000b", vld, word);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    int t;
    int t2;
    t = cyc; rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_id = ID_W'(i); rd_tag = TAG_W'(4 + i);
      step();
    end
    rd = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      checks++;
      if (done !== 1'b0) begin fails++; $display("FAIL mid_done_low c%0d: got %b expected 0", i, done); end
      checks++;
      if (vld !== 1'b0) begin fails++; $display("FAIL mid_no_resp @+%0d: got %b expected 0", cyc - t, vld); end
      step();
    end
    checks++;
    if (done !== 1'b1) begin fails++; $display("FAIL mid_done_rise: got %b expected 1", done); end
    t2 = cyc; rd = 1'b1; rd_id = 4'd1; rd_tag = 3'd6;
    step();
    rd_id = 4'd2; rd_tag = 3'd7;
    step();
    rd = 1'b0;
    while (cyc <= t2 + int'(LAT) + 2) begin
      checks++;
      if (vld !== (cyc == t2 + int'(LAT) || cyc == t2 + int'(LAT) + 1)) begin
        fails++; $display("FAIL mid_read_vld @+%0d: got %b", cyc - t2, vld);
      end
      if (cyc == t2 + int'(LAT) || cyc == t2 + int'(LAT) + 1) begin
        checks++;
        if (word !== 32'h0) begin fails++; $display("FAIL mid_cleared_word: got %h expected 00000000", word); end
        checks++;
        if (ctag !== ((cyc == t2 + int'(LAT)) ? 3'd6 : 3'd7)) begin
          fails++; $display("FAIL mid_read_tag: got %0d", ctag);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_latency();
    test_back_to_back();
    test_write_first();
    test_forward();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
